// File: rtl/vga_sdram_pkg.sv
// Shared constants for the VGA/BUS SDRAM arbiter: queue owner flags and memory command widths.
package vga_sdram_pkg;
    localparam logic FLAG_VGA   = 1'b0;
    localparam logic FLAG_BUS   = 1'b1;
    localparam int   MEM_ADDR_W = 32;
    localparam int   MEM_DATA_W = 32;
    localparam int   MEM_MASK_W = 4;
endpackage

// File: rtl/vga_arbiter_matching_queue.sv
// In-order owner-flag FIFO; push and pop in the same cycle leave occupancy unchanged.
// Full/empty are judged on the registered count; pushes while full and pops while empty are dropped.
module vga_arbiter_matching_queue #(
    parameter int D  = 8,
    parameter int DN = 3,
    parameter int FN = 1
) (
    input  logic          iCLOCK,
    input  logic          inRESET,
    input  logic          iRESET_SYNC,
    input  logic          iFLASH,
    input  logic          iWR_REQ,
    input  logic [FN-1:0] iWR_FLAG,
    output logic          oWR_FULL,
    input  logic          iRD_REQ,
    output logic [FN-1:0] oRD_FLAG,
    output logic          oRD_EMPTY
);
    logic [FN-1:0] mem_q [D];
    logic [DN-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DN:0]   count_q, count_d;
    logic          push, pop;

    assign oWR_FULL  = (count_q == (DN+1)'(D));
    assign oRD_EMPTY = (count_q == '0);
    assign oRD_FLAG  = mem_q[rd_ptr_q];
    assign push      = iWR_REQ && !oWR_FULL;
    assign pop       = iRD_REQ && !oRD_EMPTY;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + (DN+1)'(push) - (DN+1)'(pop);
        if (push) wr_ptr_d = wr_ptr_q + DN'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + DN'(1);
        if (iRESET_SYNC || iFLASH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Flag storage needs no reset: entries are only read while counted.
    always_ff @(posedge iCLOCK) begin
        if (push) mem_q[wr_ptr_q] <= iWR_FLAG;
    end
endmodule

// File: rtl/vga_sdram_arbiter.sv
// Arbitrates VGA reads and BUS reads/writes onto one registered SDRAM command port and
// steers in-order read returns back to their owner, dropping VGA words made stale by a flush.
module vga_sdram_arbiter
    import vga_sdram_pkg::*;
#(
    parameter int QD             = 8,
    parameter int QDN            = 3,
    parameter int VGA_STREAK_MAX = 4
) (
    input  logic                  iCLOCK,
    input  logic                  inRESET,
    input  logic                  iRESET_SYNC,
    input  logic                  iVGA_REQ,
    input  logic [MEM_ADDR_W-1:0] iVGA_ADDR,
    output logic                  oVGA_LOCK,
    input  logic                  iVGA_FLUSH,
    output logic                  oVGA_VALID,
    output logic [MEM_DATA_W-1:0] oVGA_DATA,
    input  logic                  iBUS_REQ,
    input  logic                  iBUS_RW,
    input  logic [MEM_ADDR_W-1:0] iBUS_ADDR,
    input  logic [MEM_DATA_W-1:0] iBUS_DATA,
    input  logic [MEM_MASK_W-1:0] iBUS_MASK,
    output logic                  oBUS_LOCK,
    output logic                  oBUS_VALID,
    output logic [MEM_DATA_W-1:0] oBUS_DATA,
    output logic                  oMEM_REQ,
    input  logic                  iMEM_LOCK,
    output logic                  oMEM_RW,
    output logic [MEM_ADDR_W-1:0] oMEM_ADDR,
    output logic [MEM_DATA_W-1:0] oMEM_DATA,
    output logic [MEM_MASK_W-1:0] oMEM_MASK,
    input  logic                  iMEM_VALID,
    input  logic [MEM_DATA_W-1:0] iMEM_DATA
);
    logic                  mem_req_q, mem_req_d, mem_rw_q, mem_rw_d;
    logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [MEM_DATA_W-1:0] mem_data_q, mem_data_d;
    logic [MEM_MASK_W-1:0] mem_mask_q, mem_mask_d;
    logic [3:0]            streak_q, streak_d;
    logic [QDN:0]          vga_out_q, vga_out_d, discard_q, discard_d;
    logic                  vga_valid_q, vga_valid_d, bus_valid_q, bus_valid_d;
    logic [MEM_DATA_W-1:0] vga_data_q, vga_data_d, bus_data_q, bus_data_d;

    logic q_full, q_empty, head_flag;
    logic slot_free, vga_ok, bus_ok, gnt_vga, gnt_bus;
    logic push, push_vga, pop, pop_vga, pop_bus;

    assign slot_free = !mem_req_q || !iMEM_LOCK;
    assign vga_ok    = iVGA_REQ && slot_free && !q_full && !iRESET_SYNC;
    assign bus_ok    = iBUS_REQ && slot_free && (iBUS_RW || !q_full) && !iRESET_SYNC;
    // VGA has priority until it has starved a waiting BUS for VGA_STREAK_MAX grants.
    assign gnt_vga   = vga_ok && !(bus_ok && (streak_q == 4'(VGA_STREAK_MAX)));
    assign gnt_bus   = bus_ok && !gnt_vga;
    assign oVGA_LOCK = !gnt_vga;
    assign oBUS_LOCK = !gnt_bus;

    assign push_vga = gnt_vga;
    assign push     = gnt_vga || (gnt_bus && !iBUS_RW);
    assign pop      = iMEM_VALID && !q_empty;
    assign pop_vga  = pop && (head_flag == FLAG_VGA);
    assign pop_bus  = pop && (head_flag == FLAG_BUS);

    vga_arbiter_matching_queue #(.D(QD), .DN(QDN), .FN(1)) u_queue (
        .iCLOCK      (iCLOCK),
        .inRESET     (inRESET),
        .iRESET_SYNC (iRESET_SYNC),
        .iFLASH      (1'b0),
        .iWR_REQ     (push),
        .iWR_FLAG    (gnt_bus ? FLAG_BUS : FLAG_VGA),
        .oWR_FULL    (q_full),
        .iRD_REQ     (iMEM_VALID),
        .oRD_FLAG    (head_flag),
        .oRD_EMPTY   (q_empty)
    );

    always_comb begin
        mem_req_d   = mem_req_q;
        mem_rw_d    = mem_rw_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        mem_mask_d  = mem_mask_q;
        streak_d    = streak_q;
        vga_out_d   = vga_out_q + (QDN+1)'(push_vga) - (QDN+1)'(pop_vga);
        discard_d   = discard_q;
        vga_valid_d = 1'b0;
        vga_data_d  = vga_data_q;
        bus_valid_d = 1'b0;
        bus_data_d  = bus_data_q;

        if (gnt_vga) begin
            mem_req_d  = 1'b1;
            mem_rw_d   = 1'b0;
            mem_addr_d = iVGA_ADDR;
            mem_data_d = '0;
            mem_mask_d = '0;
        end else if (gnt_bus) begin
            mem_req_d  = 1'b1;
            mem_rw_d   = iBUS_RW;
            mem_addr_d = iBUS_ADDR;
            mem_data_d = iBUS_DATA;
            mem_mask_d = iBUS_MASK;
        end else if (slot_free) begin
            mem_req_d  = 1'b0;
        end

        if (gnt_bus || !iBUS_REQ)             streak_d = '0;
        else if (gnt_vga && streak_q != 4'hF) streak_d = streak_q + 4'd1;

        // A flush condemns every VGA read already issued, except one returning right now.
        if (iVGA_FLUSH)                        discard_d = vga_out_q - (QDN+1)'(pop_vga);
        else if (pop_vga && discard_q != '0)   discard_d = discard_q - (QDN+1)'(1);

        if (pop_bus) begin
            bus_valid_d = 1'b1;
            bus_data_d  = iMEM_DATA;
        end
        if (pop_vga && discard_q == '0 && !iVGA_FLUSH) begin
            vga_valid_d = 1'b1;
            vga_data_d  = iMEM_DATA;
        end

        if (iRESET_SYNC) begin
            mem_req_d   = 1'b0;
            mem_rw_d    = 1'b0;
            mem_addr_d  = '0;
            mem_data_d  = '0;
            mem_mask_d  = '0;
            streak_d    = '0;
            vga_out_d   = '0;
            discard_d   = '0;
            vga_valid_d = 1'b0;
            vga_data_d  = '0;
            bus_valid_d = 1'b0;
            bus_data_d  = '0;
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            mem_req_q   <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_mask_q  <= '0;
            streak_q    <= '0;
            vga_out_q   <= '0;
            discard_q   <= '0;
            vga_valid_q <= 1'b0;
            vga_data_q  <= '0;
            bus_valid_q <= 1'b0;
            bus_data_q  <= '0;
        end else begin
            mem_req_q   <= mem_req_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_mask_q  <= mem_mask_d;
            streak_q    <= streak_d;
            vga_out_q   <= vga_out_d;
            discard_q   <= discard_d;
            vga_valid_q <= vga_valid_d;
            vga_data_q  <= vga_data_d;
            bus_valid_q <= bus_valid_d;
            bus_data_q  <= bus_data_d;
        end
    end

    assign oMEM_REQ   = mem_req_q;
    assign oMEM_RW    = mem_rw_q;
    assign oMEM_ADDR  = mem_addr_q;
    assign oMEM_DATA  = mem_data_q;
    assign oMEM_MASK  = mem_mask_q;
    assign oVGA_VALID = vga_valid_q;
    assign oVGA_DATA  = vga_data_q;
    assign oBUS_VALID = bus_valid_q;
    assign oBUS_DATA  = bus_data_q;
endmodule

// File: tb/tb_vga_sdram_arbiter.sv
// Directed bench: a queue-of-owners reference model checked every cycle, plus literal spot checks.
module tb_vga_sdram_arbiter;
    localparam int MAXS = 4;

    logic        iCLOCK = 1'b0, inRESET = 1'b1, iRESET_SYNC = 1'b0;
    logic        iVGA_REQ = 1'b0, iVGA_FLUSH = 1'b0;
    logic [31:0] iVGA_ADDR = '0;
    logic        iBUS_REQ = 1'b0, iBUS_RW = 1'b0;
    logic [31:0] iBUS_ADDR = '0, iBUS_DATA = '0;
    logic [3:0]  iBUS_MASK = '0;
    logic        iMEM_LOCK = 1'b0, iMEM_VALID = 1'b0;
    logic [31:0] iMEM_DATA = '0;
    logic        oVGA_LOCK, oVGA_VALID, oBUS_LOCK, oBUS_VALID, oMEM_REQ, oMEM_RW;
    logic [31:0] oVGA_DATA, oBUS_DATA, oMEM_ADDR, oMEM_DATA;
    logic [3:0]  oMEM_MASK;

    vga_sdram_arbiter #(.QD(8), .QDN(3), .VGA_STREAK_MAX(MAXS)) dut (
        .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
        .iVGA_REQ(iVGA_REQ), .iVGA_ADDR(iVGA_ADDR), .oVGA_LOCK(oVGA_LOCK),
        .iVGA_FLUSH(iVGA_FLUSH), .oVGA_VALID(oVGA_VALID), .oVGA_DATA(oVGA_DATA),
        .iBUS_REQ(iBUS_REQ), .iBUS_RW(iBUS_RW), .iBUS_ADDR(iBUS_ADDR),
        .iBUS_DATA(iBUS_DATA), .iBUS_MASK(iBUS_MASK), .oBUS_LOCK(oBUS_LOCK),
        .oBUS_VALID(oBUS_VALID), .oBUS_DATA(oBUS_DATA),
        .oMEM_REQ(oMEM_REQ), .iMEM_LOCK(iMEM_LOCK), .oMEM_RW(oMEM_RW),
        .oMEM_ADDR(oMEM_ADDR), .oMEM_DATA(oMEM_DATA), .oMEM_MASK(oMEM_MASK),
        .iMEM_VALID(iMEM_VALID), .iMEM_DATA(iMEM_DATA)
    );

    always #5 iCLOCK = ~iCLOCK;

    int total = 0, bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding reads as a list of owners, each with a "stale" mark.
    bit          m_req = 0, m_rw = 0, m_vval = 0, m_bval = 0;
    logic [31:0] m_addr = '0, m_wdat = '0, m_vdat = '0, m_bdat = '0;
    logic [3:0]  m_mask = '0;
    int          m_streak = 0;
    bit          own_q[$];
    bit          dead_q[$];

    function automatic void grants(output bit gv, output bit gb);
        bit free, full, vok, bok;
        free = !m_req || !iMEM_LOCK;
        full = own_q.size() >= 8;
        vok  = iVGA_REQ && free && !full && !iRESET_SYNC;
        bok  = iBUS_REQ && free && (iBUS_RW || !full) && !iRESET_SYNC;
        if (vok && bok) begin
            gv = (m_streak != MAXS);
            gb = !gv;
        end else begin
            gv = vok;
            gb = bok;
        end
    endfunction

    function automatic void model_clear();
        m_req = 0; m_rw = 0; m_addr = '0; m_wdat = '0; m_mask = '0;
        m_vval = 0; m_bval = 0; m_vdat = '0; m_bdat = '0; m_streak = 0;
        own_q.delete();
        dead_q.delete();
    endfunction

    initial forever begin
        bit gv, gb, o, d;
        @(posedge iCLOCK or negedge inRESET);
        if (!inRESET || iRESET_SYNC) begin
            model_clear();
        end else begin
            grants(gv, gb);
            m_vval = 0;
            m_bval = 0;
            if (iMEM_VALID && own_q.size() > 0) begin
                o = own_q.pop_front();
                d = dead_q.pop_front();
                if (o) begin
                    m_bval = 1; m_bdat = iMEM_DATA;
                end else if (!d && !iVGA_FLUSH) begin
                    m_vval = 1; m_vdat = iMEM_DATA;
                end
            end
            if (iVGA_FLUSH)
                foreach (own_q[i]) if (!own_q[i]) dead_q[i] = 1;
            if (gv) begin
                m_req = 1; m_rw = 0; m_addr = iVGA_ADDR;
                own_q.push_back(0); dead_q.push_back(0);
            end else if (gb) begin
                m_req = 1; m_rw = iBUS_RW; m_addr = iBUS_ADDR; m_wdat = iBUS_DATA; m_mask = iBUS_MASK;
                if (!iBUS_RW) begin
                    own_q.push_back(1); dead_q.push_back(0);
                end
            end else if (!m_req || !iMEM_LOCK) begin
                m_req = 0;
            end
            if (gb || !iBUS_REQ)          m_streak = 0;
            else if (gv && m_streak < 15) m_streak++;
        end
    end

    initial forever begin
        bit gv, gb;
        @(negedge iCLOCK);
        if (chk_en) begin
            grants(gv, gb);
            check("vga_lock", 32'(oVGA_LOCK), 32'(!gv));
            check("bus_lock", 32'(oBUS_LOCK), 32'(!gb));
            check("mem_req", 32'(oMEM_REQ), 32'(m_req));
            if (m_req) begin
                check("mem_rw", 32'(oMEM_RW), 32'(m_rw));
                check("mem_addr", oMEM_ADDR, m_addr);
                if (m_rw) begin
                    check("mem_data", oMEM_DATA, m_wdat);
                    check("mem_mask", 32'(oMEM_MASK), 32'(m_mask));
                end
            end
            check("vga_valid", 32'(oVGA_VALID), 32'(m_vval));
            check("vga_data", oVGA_DATA, m_vdat);
            check("bus_valid", 32'(oBUS_VALID), 32'(m_bval));
            check("bus_data", oBUS_DATA, m_bdat);
        end
    end

    task automatic step();
        @(posedge iCLOCK);
        #2;
    endtask

    task automatic issue_vga(input logic [31:0] a);
        iVGA_REQ = 1; iVGA_ADDR = a; step(); iVGA_REQ = 0;
    endtask

    task automatic issue_bus_rd(input logic [31:0] a);
        iBUS_REQ = 1; iBUS_RW = 0; iBUS_ADDR = a; step(); iBUS_REQ = 0;
    endtask

    task automatic ret(input logic [31:0] d);
        iMEM_VALID = 1; iMEM_DATA = d; step(); iMEM_VALID = 0;
    endtask

    bit [9:0] gbus, gvga;
    bit [4:0] eb, ev;

    initial begin
        #1 inRESET = 0;
        repeat (3) step();
        inRESET = 1;
        step();
        chk_en = 1;
        check("rst_mem_req", 32'(oMEM_REQ), 32'd0);
        check("rst_vga_valid", 32'(oVGA_VALID), 32'd0);
        check("rst_bus_valid", 32'(oBUS_VALID), 32'd0);

        // Single VGA read, returned three cycles after issue.
        iVGA_REQ = 1; iVGA_ADDR = 32'h100;
        #1 check("t1_accept", 32'(oVGA_LOCK), 32'd0);
        step();
        iVGA_REQ = 0;
        check("t1_req", 32'(oMEM_REQ), 32'd1);
        check("t1_addr", oMEM_ADDR, 32'h100);
        step();
        check("t1_req_drop", 32'(oMEM_REQ), 32'd0);
        step();
        ret(32'hA5A5A5A5);
        check("t1_vvalid", 32'(oVGA_VALID), 32'd1);
        check("t1_vdata", oVGA_DATA, 32'hA5A5A5A5);
        check("t1_bvalid", 32'(oBUS_VALID), 32'd0);
        step();
        check("t1_pulse", 32'(oVGA_VALID), 32'd0);

        // Both requesting continuously: four VGA grants then one BUS grant.
        iVGA_REQ = 1; iVGA_ADDR = 32'h800;
        iBUS_REQ = 1; iBUS_RW = 1; iBUS_ADDR = 32'h900; iBUS_DATA = 32'h5; iBUS_MASK = 4'h1;
        iMEM_VALID = 1; iMEM_DATA = 32'h42;
        for (int i = 0; i < 10; i++) begin
            #1;
            gbus[i] = !oBUS_LOCK;
            gvga[i] = !oVGA_LOCK;
            step();
        end
        iVGA_REQ = 0; iBUS_REQ = 0; iMEM_VALID = 0;
        check("t2_bus_pattern", 32'(gbus), 32'h210);
        check("t2_vga_pattern", 32'(gvga), 32'h1EF);
        repeat (2) step();
        iMEM_VALID = 1;
        repeat (3) step();
        iMEM_VALID = 0;

        // SDRAM stalled with a command pending.
        iBUS_REQ = 1; iBUS_RW = 1; iBUS_ADDR = 32'h300; iBUS_DATA = 32'h11223344; iBUS_MASK = 4'h3;
        step();
        iBUS_ADDR = 32'h304; iVGA_REQ = 1; iVGA_ADDR = 32'h400; iMEM_LOCK = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3_vlock", 32'(oVGA_LOCK), 32'd1);
            check("t3_block", 32'(oBUS_LOCK), 32'd1);
            step();
            check("t3_hold_addr", oMEM_ADDR, 32'h300);
            check("t3_hold_data", oMEM_DATA, 32'h11223344);
        end
        iMEM_LOCK = 0;
        #1 check("t3_vga_wins", 32'(oVGA_LOCK), 32'd0);
        step();
        iVGA_REQ = 0;
        check("t3_addr", oMEM_ADDR, 32'h400);
        step();
        iBUS_REQ = 0;
        step();
        ret(32'hCAFE0001);
        check("t3_ret", oVGA_DATA, 32'hCAFE0001);

        // Eight reads outstanding: reads lock, a write still goes.
        for (int i = 0; i < 8; i++) begin
            iVGA_REQ = 1; iVGA_ADDR = 32'h1000 + 32'(i * 4);
            step();
        end
        #1 check("t4_vga_full", 32'(oVGA_LOCK), 32'd1);
        iBUS_REQ = 1; iBUS_RW = 0; iBUS_ADDR = 32'h204;
        #1 check("t4_busrd_full", 32'(oBUS_LOCK), 32'd1);
        iBUS_RW = 1; iBUS_ADDR = 32'h200; iBUS_DATA = 32'hDEADBEEF; iBUS_MASK = 4'hF;
        #1 check("t4_write_ok", 32'(oBUS_LOCK), 32'd0);
        step();
        iBUS_REQ = 0; iVGA_REQ = 0;
        check("t4_rw", 32'(oMEM_RW), 32'd1);
        check("t4_addr", oMEM_ADDR, 32'h200);
        check("t4_data", oMEM_DATA, 32'hDEADBEEF);
        check("t4_mask", 32'(oMEM_MASK), 32'hF);
        for (int i = 0; i < 8; i++) ret(32'hB000 + 32'(i));
        check("t4_last", oVGA_DATA, 32'hB007);

        // Flush with V,B,V,B outstanding, plus a VGA read pushed in the flush cycle.
        issue_vga(32'h600);
        issue_bus_rd(32'h604);
        issue_vga(32'h608);
        issue_bus_rd(32'h60C);
        iVGA_FLUSH = 1; iVGA_REQ = 1; iVGA_ADDR = 32'h610;
        step();
        iVGA_FLUSH = 0; iVGA_REQ = 0;
        eb = 5'b01010;
        ev = 5'b10000;
        for (int i = 0; i < 5; i++) begin
            ret(32'h10 + 32'(i));
            check("t5_bvalid", 32'(oBUS_VALID), 32'(eb[i]));
            check("t5_vvalid", 32'(oVGA_VALID), 32'(ev[i]));
            if (eb[i]) check("t5_bdata", oBUS_DATA, 32'h10 + 32'(i));
            if (ev[i]) check("t5_vdata", oVGA_DATA, 32'h10 + 32'(i));
        end

        // Flush in the same cycle a VGA word returns: both pending VGA words are dropped.
        issue_vga(32'h620);
        issue_vga(32'h624);
        iVGA_FLUSH = 1;
        ret(32'h21);
        iVGA_FLUSH = 0;
        check("t5b_drop0", 32'(oVGA_VALID), 32'd0);
        ret(32'h22);
        check("t5b_drop1", 32'(oVGA_VALID), 32'd0);
        issue_vga(32'h628);
        ret(32'h23);
        check("t5b_live", 32'(oVGA_VALID), 32'd1);

        // Synchronous clear with three reads outstanding.
        issue_vga(32'h700);
        issue_bus_rd(32'h704);
        issue_vga(32'h708);
        iRESET_SYNC = 1;
        step();
        iRESET_SYNC = 0;
        check("t6_req", 32'(oMEM_REQ), 32'd0);
        check("t6_addr", oMEM_ADDR, 32'd0);
        check("t6_vvalid", 32'(oVGA_VALID), 32'd0);
        ret(32'h99);
        check("t6_empty_v", 32'(oVGA_VALID), 32'd0);
        check("t6_empty_b", 32'(oBUS_VALID), 32'd0);
        issue_bus_rd(32'h710);
        ret(32'h55);
        check("t6_bus_after", 32'(oBUS_VALID), 32'd1);
        check("t6_bus_data", oBUS_DATA, 32'h55);
        check("t6_no_vga", 32'(oVGA_VALID), 32'd0);

        repeat (3) step();
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_sdram_arbiter.md
# vga_sdram_arbiter

Shares the single SDRAM request port of the VGA memory subsystem between the display-refresh reader (VGA) and the CPU bus port (BUS). It grants one requester per cycle and registers the winning command toward SDRAM. For every read it records the requester in an in-order matching queue, then steers each returning read word to its owner. VGA reads issued before a display flush are discarded on return without disturbing outstanding BUS reads.

## Interface
- QD, 8, matching-queue depth (power of two)
- QDN, 3, log2(QD)
- VGA_STREAK_MAX, 4, consecutive VGA grants allowed while BUS waits (1..15)
- iCLOCK  in  1  clock
- inRESET  in  1  asynchronous, active-low reset
- iRESET_SYNC  in  1  synchronous clear of all state
- iVGA_REQ  in  1  VGA read request; hold until accepted
- iVGA_ADDR  in  32  VGA read address
- oVGA_LOCK  out  1  1 = request not accepted this cycle
- iVGA_FLUSH  in  1  discard all VGA reads outstanding before this cycle
- oVGA_VALID  out  1  VGA read data valid (one-cycle pulse)
- oVGA_DATA  out  32  VGA read data
- iBUS_REQ  in  1  BUS request; hold until accepted
- iBUS_RW  in  1  1 = write, 0 = read
- iBUS_ADDR  in  32  address
- iBUS_DATA  in  32  write data
- iBUS_MASK  in  4  byte enables
- oBUS_LOCK  out  1  1 = request not accepted this cycle
- oBUS_VALID  out  1  BUS read data valid (one-cycle pulse)
- oBUS_DATA  out  32  BUS read data
- oMEM_REQ  out  1  command valid toward SDRAM
- iMEM_LOCK  in  1  SDRAM cannot accept; oMEM_* held
- oMEM_RW, oMEM_ADDR, oMEM_DATA, oMEM_MASK  out  1/32/32/4  registered command
- iMEM_VALID  in  1  read data return, strictly in issue order
- iMEM_DATA  in  32  read data

## Operation
- Acceptance: requester X accepted in cycle n when iX_REQ && !oX_LOCK. oX_LOCK is combinational.
- Slot free when !oMEM_REQ || !iMEM_LOCK. No acceptance unless slot free.
- A read (VGA, or BUS with RW=0) additionally requires matching queue not full. A BUS write ignores queue state.
- Grant:
  - Only one eligible requester: it wins.
  - Both eligible: VGA wins, unless streak == VGA_STREAK_MAX, in which case BUS wins.
- streak (4 bit, reset 0):
  - +1 on VGA grant while BUS requesting, saturating.
  - Cleared on any BUS grant.
  - Cleared when BUS is not requesting.
- On accept: load oMEM_* from the winner and set oMEM_REQ=1. Reads push a flag (FLAG_VGA/FLAG_BUS) into the queue in the same cycle.
- Slot free with no grant: oMEM_REQ <= 0.
- Return: iMEM_VALID pops the queue head.
  - Flag BUS: oBUS_VALID/oBUS_DATA next cycle.
  - Flag VGA with discard==0: oVGA_VALID/oVGA_DATA next cycle.
  - Flag VGA with discard>0: dropped; discard -1.
- vga_out (QDN+1 bits): +1 on VGA push, -1 on VGA pop.
- iVGA_FLUSH sets discard <= vga_out − (VGA pop this cycle ? 1 : 0), and drops a VGA return popped in that same cycle. A VGA push in the flush cycle is not discarded.
- iMEM_VALID with queue empty: ignored, no output pulse.
- iRESET_SYNC or inRESET: queue, counters, streak cleared; all outputs 0.

## Timing
- Reset value of every output is 0, except oVGA_LOCK/oBUS_LOCK, which follow their combinational rule.
- Accept at cycle n → oMEM_REQ=1 at n+1. Command held until a cycle with iMEM_LOCK=0.
- Back-to-back accepts are possible every cycle while iMEM_LOCK=0.
- iMEM_VALID at cycle m → oX_VALID at m+1, for exactly 1 cycle.
- Simultaneous push and pop keeps queue occupancy unchanged. Full is judged on the pre-cycle count.
- iRESET_SYNC has priority over every other input in its cycle.

## Structure
- Package vga_sdram_pkg: FLAG_VGA=1'b0, FLAG_BUS=1'b1, MEM_ADDR_W=32, MEM_DATA_W=32, MEM_MASK_W=4.
- Sub-module: vga_arbiter_matching_queue (D=QD, DN=QDN, FN=1), with iFLASH tied 0. Discard logic lives in the arbiter.

## Test plan
- Single VGA read 0x100, iMEM_LOCK=0, data 0xA5A5A5A5 returned 3 cycles after issue → oMEM_REQ at n+1, oVGA_VALID with 0xA5A5A5A5 one cycle after return, oBUS_VALID stays 0.
- Both requesting continuously, VGA_STREAK_MAX=4 → grant pattern VGA,VGA,VGA,VGA,BUS repeating.
- iMEM_LOCK=1 for 5 cycles with command pending → oMEM_* stable, both LOCKs high, no queue push.
- 8 outstanding reads, no returns → further reads locked; a BUS write (0x200, 0xDEADBEEF, mask 0xF) still issues.
- Interleaved returns V,B,V,B with iVGA_FLUSH asserted after issue → only the BUS returns appear, in order. A VGA read pushed in the flush cycle is delivered.
- Assert iRESET_SYNC with 3 reads outstanding → all outputs 0, queue empty; a later return with empty queue produces no pulse.
